// File: rtl/adder_result_collector_if.sv
// ----------------------------------------------------------------------------
// adder_result_collector_if
//   Bundles the collector's issue handshake, adder result inputs and the
//   ready/valid drain port.
//   slave  : collector side (drives issue_ready and the out_* / count signals)
//   master : issuer/sink side (drives issue_valid, add_s, add_co, out_ready)
//   Optional feature macro: ADDER_RESULT_ZERO_FLAG_EN adds out_zero.
// Parameters
//   CW : width of the occupancy count
// ----------------------------------------------------------------------------
interface adder_result_collector_if #(
    parameter int CW = 4
) ();
    logic          issue_valid;
    logic          issue_ready;
    logic [31:0]   add_s;
    logic          add_co;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_sum;
    logic          out_co;
    logic [CW-1:0] count;
`ifdef ADDER_RESULT_ZERO_FLAG_EN
    logic          out_zero;

    modport slave (
        input  issue_valid, add_s, add_co, out_ready,
        output issue_ready, out_valid, out_sum, out_co, count, out_zero
    );
    modport master (
        output issue_valid, add_s, add_co, out_ready,
        input  issue_ready, out_valid, out_sum, out_co, count, out_zero
    );
`else
    modport slave (
        input  issue_valid, add_s, add_co, out_ready,
        output issue_ready, out_valid, out_sum, out_co, count
    );
    modport master (
        output issue_valid, add_s, add_co, out_ready,
        input  issue_ready, out_valid, out_sum, out_co, count
    );
`endif
endinterface

// File: rtl/adder_result_collector.sv
// ----------------------------------------------------------------------------
// adder_result_collector
//   Sits behind a fixed-latency 32-bit pipelined adder. A valid bit travels
//   in a delay line alongside the adder pipe; when it reaches the end, the
//   adder's {co,s} is written into a first-word-fall-through FIFO that is
//   drained over a ready/valid port. Issue is gated by credits so that every
//   in-flight result always has a free FIFO slot waiting for it.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.issue_valid / bus.issue_ready : issue handshake (fire = both high)
//   bus.add_s / bus.add_co            : adder result outputs
//   bus.out_valid / bus.out_ready     : drain handshake (pop = both high)
//   bus.out_sum / bus.out_co          : head entry
//   bus.count                         : FIFO occupancy 0..DEPTH
//   bus.out_zero                      : head sum==0 (only with the macro)
// Optional feature macro: ADDER_RESULT_ZERO_FLAG_EN
// ----------------------------------------------------------------------------

// Flags a push that would overrun the result FIFO (credit scheme broken).
module adder_result_collector_chk #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push_i,
    input logic [CW-1:0] count_i
);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && (count_i == FULL_C)))
        else $error("adder_result_collector: push into full FIFO");
endmodule

module adder_result_collector #(
    parameter int ADD_LAT = 4,
    parameter int DEPTH   = 8,
    parameter int CW      = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    adder_result_collector_if.slave bus
);
    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
`ifdef ADDER_RESULT_ZERO_FLAG_EN
    localparam int EW = 34;
`else
    localparam int EW = 33;
`endif
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    // Number of set bits in the valid delay line (results still in the adder).
    function automatic logic [31:0] popcount(input logic [ADD_LAT-1:0] v);
        logic [31:0] n;
        n = 32'd0;
        for (int i = 0; i < ADD_LAT; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    logic [ADD_LAT-1:0] vld_sr_q, vld_sr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               issue_ready_q, issue_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [EW-1:0]      mem_q [DEPTH];
    logic [EW-1:0]      mem_d [DEPTH];

    logic               fire_s;
    logic               push_s;
    logic               pop_s;
    logic [EW-1:0]      wr_entry_s;
    logic [31:0]        credit_s;

    // Handshake decode and the entry to be written on push.
    always_comb begin
        fire_s = bus.issue_valid && issue_ready_q;
        push_s = vld_sr_q[ADD_LAT-1];
        pop_s  = out_valid_q && bus.out_ready;
`ifdef ADDER_RESULT_ZERO_FLAG_EN
        wr_entry_s = {(bus.add_s == 32'h0000_0000), bus.add_co, bus.add_s};
`else
        wr_entry_s = {bus.add_co, bus.add_s};
`endif
    end

    // Next-state for delay line, pointers, occupancy, storage and flags.
    always_comb begin
        vld_sr_d    = vld_sr_q;
        vld_sr_d[0] = fire_s;
        for (int i = 1; i < ADD_LAT; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase

        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push_s) begin
            mem_d[wr_ptr_q] = wr_entry_s;
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end

        // Flags are registered from next-state values, so they equal the
        // same functions of the current registers one cycle later; a pop
        // this cycle therefore frees a credit only from the next cycle on.
        credit_s      = 32'(count_d) + popcount(vld_sr_d);
        issue_ready_d = (credit_s < DEPTH_U);
        out_valid_d   = (count_d != {CW{1'b0}});
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr_q      <= {ADD_LAT{1'b0}};
            wr_ptr_q      <= {PW{1'b0}};
            rd_ptr_q      <= {PW{1'b0}};
            count_q       <= {CW{1'b0}};
            issue_ready_q <= 1'b1;
            out_valid_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {EW{1'b0}};
            end
        end else begin
            vld_sr_q      <= vld_sr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            issue_ready_q <= issue_ready_d;
            out_valid_q   <= out_valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.issue_ready = issue_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.count       = count_q;
    // Head shown straight from storage (FWFT); it only moves on a pop.
    assign bus.out_sum     = mem_q[rd_ptr_q][31:0];
    assign bus.out_co      = mem_q[rd_ptr_q][32];
`ifdef ADDER_RESULT_ZERO_FLAG_EN
    assign bus.out_zero    = mem_q[rd_ptr_q][33];
`endif

    adder_result_collector_chk #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .count_i (count_q)
    );
endmodule

// File: tb/tb_adder_result_collector.sv
// ----------------------------------------------------------------------------
// tb_adder_result_collector
//   Drives a behavioural ADD_LAT-stage adder pipe into the collector. Every
//   fire pushes the bench's own {zero,co,sum} into a scoreboard queue; every
//   pop compares the DUT head against the queue front.
// ----------------------------------------------------------------------------
module tb_adder_result_collector;
    localparam int ADD_LAT = 4;
    localparam int DEPTH   = 8;
    localparam int CW      = 4;

    logic clk;
    logic rst_n;
    logic [31:0] a, b;
    logic ci;

    int checks = 0;
    int errors = 0;
    int fire_cnt = 0;
    int pop_cnt = 0;
    int max_cnt = 0;
    int cyc = 0;
    logic [33:0] sb [$];
    int pop_cyc_q [$];

    adder_result_collector_if #(.CW(CW)) bus ();

    adder_result_collector #(
        .ADD_LAT (ADD_LAT),
        .DEPTH   (DEPTH),
        .CW      (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural adder pipe (not reset, like the real one).
    logic [32:0] pipe [ADD_LAT];
    always @(posedge clk) begin
        pipe[0] <= {1'b0, a} + {1'b0, b} + {32'd0, ci};
        for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.add_s  = pipe[ADD_LAT-1][31:0];
    assign bus.add_co = pipe[ADD_LAT-1][32];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Monitor: sampled mid-cycle, ahead of the edge that commits fire/pop.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [32:0] r;
            if (32'(bus.count) > 32'(max_cnt)) max_cnt <= int'(bus.count);
            if (bus.issue_valid && bus.issue_ready) begin
                r = {1'b0, a} + {1'b0, b} + {32'd0, ci};
                sb.push_back({(r[31:0] == 32'h0), r});
                fire_cnt <= fire_cnt + 1;
            end
            if (bus.out_valid && bus.out_ready) begin
                pop_cnt <= pop_cnt + 1;
                pop_cyc_q.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_pop", 32'd1, 32'd0);
                end else begin
                    check("pop_sum", bus.out_sum, sb[0][31:0]);
                    check("pop_co", {31'd0, bus.out_co}, {31'd0, sb[0][32]});
`ifdef ADDER_RESULT_ZERO_FLAG_EN
                    check("pop_zero", {31'd0, bus.out_zero}, {31'd0, sb[0][33]});
`endif
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Drive one request and hold it until it fires (called at posedge+1).
    task automatic issue_one(input logic [31:0] ta, input logic [31:0] tb, input logic tci);
        int f0;
        int budget;
        f0 = fire_cnt;
        budget = 0;
        a = ta; b = tb; ci = tci;
        bus.issue_valid = 1'b1;
        do begin
            @(posedge clk); #1;
            budget++;
        end while (fire_cnt == f0 && budget < 50);
        bus.issue_valid = 1'b0;
        check("issue_fired", 32'(fire_cnt - f0), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!bus.out_valid && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check(tag, {31'd0, bus.out_valid}, 32'd1);
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 0;
        bus.out_ready = 1'b1;
        while (sb.size() != 0 && budget < 300) begin
            @(posedge clk); #1;
            budget++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    // Hold issue_valid until n more fires; optionally toggle out_ready.
    task automatic stream(input int n, input bit toggle);
        int f0;
        int budget;
        f0 = fire_cnt;
        budget = 0;
        bus.issue_valid = 1'b1;
        a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
        while (fire_cnt - f0 < n && budget < 500) begin
            @(posedge clk); #1;
            budget++;
            a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
            if (toggle) bus.out_ready = ~bus.out_ready;
        end
        bus.issue_valid = 1'b0;
        check("stream_fires", 32'(fire_cnt - f0), 32'(n));
    endtask

    initial begin
        int f0;
        int p0;
        int budget;
        rst_n = 1'b0;
        bus.issue_valid = 1'b0;
        bus.out_ready = 1'b1;
        a = 32'h0; b = 32'h0; ci = 1'b0;

        // 1. reset state and idle
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_issue_ready", {31'd0, bus.issue_ready}, 32'd1);
        check("rst_out_sum", bus.out_sum, 32'd0);
        check("rst_out_co", {31'd0, bus.out_co}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_pops", 32'(pop_cnt), 32'd0);
        check("idle_count", 32'(bus.count), 32'd0);

        // 2. single issue, exact latency
        issue_one(32'h0000_2475, 32'h3056_1c86, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("t2_valid_c%0d", c), {31'd0, bus.out_valid}, {31'd0, (c == 5)});
            if (c == 5) begin
                check("t2_sum", bus.out_sum, 32'h3056_40fb);
                check("t2_co", {31'd0, bus.out_co}, 32'd0);
            end
        end
        @(posedge clk); #1;

        // 3. carry / wrap
        issue_one(32'hffff_ffff, 32'h0000_0001, 1'b0);
        wait_valid("t3a_valid");
        check("t3a_sum", bus.out_sum, 32'h0000_0000);
        check("t3a_co", {31'd0, bus.out_co}, 32'd1);
`ifdef ADDER_RESULT_ZERO_FLAG_EN
        check("t3a_zero", {31'd0, bus.out_zero}, 32'd1);
`endif
        @(posedge clk); #1;
        issue_one(32'hb475_0109, 32'h5c86_ba90, 1'b1);
        wait_valid("t3b_valid");
        check("t3b_sum", bus.out_sum, 32'h10fb_bb9a);
        check("t3b_co", {31'd0, bus.out_co}, 32'd1);
        @(posedge clk); #1;
        drain("t3_drain");

        // 4. back-pressure: exactly DEPTH credits
        bus.out_ready = 1'b0;
        f0 = fire_cnt;
        p0 = pop_cnt;
        bus.issue_valid = 1'b1;
        repeat (30) begin
            a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus.issue_valid = 1'b0;
        check("t4_fires", 32'(fire_cnt - f0), 32'd8);
        check("t4_issue_ready", {31'd0, bus.issue_ready}, 32'd0);
        check("t4_count", 32'(bus.count), 32'd8);
        drain("t4_drain");
        repeat (2) @(posedge clk);
        #1;
        check("t4_pops", 32'(pop_cnt - p0), 32'd8);

        // 5. streaming, then toggled back-pressure
        pop_cyc_q.delete();
        stream(20, 1'b0);
        drain("t5_drain");
        repeat (2) @(posedge clk);
        #1;
        check("t5_pop_n", 32'(pop_cyc_q.size()), 32'd20);
        if (pop_cyc_q.size() == 20)
            check("t5_back_to_back", 32'(pop_cyc_q[19] - pop_cyc_q[0]), 32'd19);
        max_cnt = 0;
        bus.out_ready = 1'b1;
        stream(20, 1'b1);
        drain("t5t_drain");
        check("t5t_max_count_over", {31'd0, (max_cnt > DEPTH)}, 32'd0);
        check("t5t_balance", 32'(fire_cnt - pop_cnt), 32'd0);

        // 6. reset mid-flight: 2 stored + 3 in flight
        bus.out_ready = 1'b0;
        issue_one(32'h1111_1111, 32'h2222_2222, 1'b0);
        issue_one(32'h3333_3333, 32'h4444_4444, 1'b1);
        budget = 0;
        while (bus.count != 4'd2 && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        check("t6_stored", 32'(bus.count), 32'd2);
        f0 = fire_cnt;
        bus.issue_valid = 1'b1;
        budget = 0;
        while (fire_cnt - f0 < 3 && budget < 20) begin
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
            budget++;
        end
        bus.issue_valid = 1'b0;
        check("t6_inflight_fires", 32'(fire_cnt - f0), 32'd3);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("t6_rst_count", 32'(bus.count), 32'd0);
        check("t6_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t6_rst_ready", {31'd0, bus.issue_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < ADD_LAT + 2; c++) begin
            @(negedge clk);
            check("t6_no_stale", {31'd0, bus.out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        issue_one(32'h0000_0010, 32'h0000_0020, 1'b0);
        wait_valid("t6_post_valid");
        check("t6_post_sum", bus.out_sum, 32'h0000_0030);
        @(posedge clk); #1;
        drain("t6_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
